// File: rtl/tick_scheduler.sv
// Four-channel tick-based timer: a clock divider produces a base tick, each channel
// counts ticks down to an expiry, and a round-robin arbiter hands expiry events out.
module tick_scheduler #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int TICK_FREQ = 1000
) (
   input  logic        clk100Mhz,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_ch,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_period,
   output logic [3:0]  busy,
   output logic [3:0]  ovr,
   output logic        evt_valid,
   output logic [1:0]  evt_ch,
   input  logic        evt_ready
);

   localparam int TICK_CNT = CLK_FREQ / TICK_FREQ;
   localparam int DIV_W    = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_STOP = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_e;

   logic [DIV_W-1:0] div_q;
   logic             tick;
   logic             rdy_q;

   arb_state_e state_q, state_d;
   logic [1:0] evt_ch_q;
   logic [1:0] rr_q;
   logic [3:0] pending;
   logic       hs;
   logic       any_pend;
   logic [1:0] sel;

   // ---------------------------------------------------------------- divider
   assign tick = (div_q == DIV_W'(TICK_CNT - 1));

   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         div_q <= tick ? '0 : div_q + DIV_W'(1);
         rdy_q <= 1'b1;
      end
   end

   assign cmd_ready = rdy_q;

   // ---------------------------------------------------------------- channels
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_ch
         logic        active_q, active_d;
         logic        periodic_q, periodic_d;
         logic [15:0] period_q, period_d;
         logic [15:0] remain_q, remain_d;
         logic        pending_q, pending_d;
         logic        ovr_q, ovr_d;
         logic        cmd_hit;
         logic        clr;
         logic        expire;

         assign cmd_hit = cmd_valid && (cmd_ch == 2'(gi)) && (cmd_op != OP_NOP);
         assign clr     = hs && (evt_ch_q == 2'(gi));

         // A command to this channel masks a coincident tick for this channel only.
         always_comb begin
            active_d   = active_q;
            periodic_d = periodic_q;
            period_d   = period_q;
            remain_d   = remain_q;
            ovr_d      = ovr_q;
            expire     = 1'b0;
            if (cmd_hit) begin
               ovr_d = 1'b0;
               if (cmd_op == OP_STOP) begin
                  active_d = 1'b0;
               end else begin
                  period_d   = (cmd_period == 16'd0) ? 16'd1 : cmd_period;
                  remain_d   = (cmd_period == 16'd0) ? 16'd1 : cmd_period;
                  periodic_d = cmd_op[1];
                  active_d   = 1'b1;
               end
            end else if (tick && active_q) begin
               if (remain_q > 16'd1) begin
                  remain_d = remain_q - 16'd1;
               end else begin
                  expire = 1'b1;
                  if (periodic_q) begin
                     remain_d = period_q;
                  end else begin
                     active_d = 1'b0;
                  end
               end
            end
            if (expire && pending_q && !clr) begin
               ovr_d = 1'b1;
            end
            pending_d = (pending_q && !clr) || expire;
         end

         always_ff @(posedge clk100Mhz or negedge rst_n) begin
            if (!rst_n) begin
               active_q   <= 1'b0;
               periodic_q <= 1'b0;
               period_q   <= '0;
               remain_q   <= '0;
               pending_q  <= 1'b0;
               ovr_q      <= 1'b0;
            end else begin
               active_q   <= active_d;
               periodic_q <= periodic_d;
               period_q   <= period_d;
               remain_q   <= remain_d;
               pending_q  <= pending_d;
               ovr_q      <= ovr_d;
            end
         end

         assign busy[gi]    = active_q;
         assign ovr[gi]     = ovr_q;
         assign pending[gi] = pending_q;
      end
   endgenerate

   // ---------------------------------------------------------------- arbiter
   // Round-robin search starting at rr_q for the first pending channel.
   always_comb begin
      logic [1:0] idx;
      any_pend = 1'b0;
      sel      = 2'd0;
      idx      = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_q + 2'(k);
         if (!any_pend && pending[idx]) begin
            any_pend = 1'b1;
            sel      = idx;
         end
      end
   end

   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_pend)  state_d = OFFER;
         OFFER:   if (evt_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      evt_valid = 1'b0;
      hs        = 1'b0;
      if (state_q == OFFER) begin
         evt_valid = 1'b1;
         hs        = evt_ready;
      end
   end

   // evt_ch is only loaded in IDLE, so it cannot move while an event is offered.
   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         evt_ch_q <= 2'd0;
         rr_q     <= 2'd0;
      end else begin
         if (state_q == IDLE && any_pend) begin
            evt_ch_q <= sel;
         end
         if (hs) begin
            rr_q <= evt_ch_q + 2'd1;
         end
      end
   end

   assign evt_ch = evt_ch_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomised and directed bench for tick_scheduler with a behavioural reference model
// and an event scoreboard; tick period is 10 clocks.
module tb_tick_scheduler;

   localparam int TCNT = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_ch = 2'd0;
   logic [1:0]  cmd_op = 2'd0;
   logic [15:0] cmd_period = 16'd0;
   logic [3:0]  busy;
   logic [3:0]  ovr;
   logic        evt_valid;
   logic [1:0]  evt_ch;
   logic        evt_ready = 1'b1;

   int errors = 0;
   int checks = 0;

   tick_scheduler #(.CLK_FREQ(100), .TICK_FREQ(10)) dut (
      .clk100Mhz (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_ch    (cmd_ch),
      .cmd_op    (cmd_op),
      .cmd_period(cmd_period),
      .busy      (busy),
      .ovr       (ovr),
      .evt_valid (evt_valid),
      .evt_ch    (evt_ch),
      .evt_ready (evt_ready)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------ reference model
   int m_div;
   bit m_act[4];
   bit m_per[4];
   int m_prd[4];
   int m_rem[4];
   bit m_pend[4];
   bit m_ovr[4];
   bit m_off;
   int m_ch;
   int m_rr;
   bit m_rdy;
   int exp_q[$];

   task automatic model_reset();
      m_div = 0;
      for (int c = 0; c < 4; c++) begin
         m_act[c] = 0; m_per[c] = 0; m_prd[c] = 0; m_rem[c] = 0;
         m_pend[c] = 0; m_ovr[c] = 0;
      end
      m_off = 0; m_ch = 0; m_rr = 0; m_rdy = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit tk, hs, ex, clr;
      bit old_pend[4];
      tk = (m_div == TCNT - 1);
      m_div = tk ? 0 : m_div + 1;
      hs = m_off && evt_ready;
      for (int c = 0; c < 4; c++) old_pend[c] = m_pend[c];
      for (int c = 0; c < 4; c++) begin
         ex  = 0;
         clr = hs && (m_ch == c);
         if (cmd_valid && int'(cmd_ch) == c && cmd_op != 2'd0) begin
            m_ovr[c] = 0;
            if (cmd_op == 2'd3) begin
               m_act[c] = 0;
            end else begin
               m_prd[c] = (cmd_period == 0) ? 1 : int'(cmd_period);
               m_rem[c] = m_prd[c];
               m_per[c] = (cmd_op == 2'd2);
               m_act[c] = 1;
            end
         end else if (tk && m_act[c]) begin
            if (m_rem[c] > 1) m_rem[c]--;
            else begin
               ex = 1;
               if (m_per[c]) m_rem[c] = m_prd[c];
               else m_act[c] = 0;
            end
         end
         if (ex && m_pend[c] && !clr) m_ovr[c] = 1;
         m_pend[c] = (m_pend[c] && !clr) || ex;
      end
      if (m_off) begin
         if (evt_ready) begin
            m_off = 0;
            m_rr  = (m_ch + 1) % 4;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (!m_off && old_pend[(m_rr + k) % 4]) begin
               m_ch  = (m_rr + k) % 4;
               m_off = 1;
               exp_q.push_back(m_ch);
            end
         end
      end
      m_rdy = 1;
   endtask

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   // ------------------------------------------------------------ checking
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [3:0] pack4(input bit v[4]);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = v[c];
      return r;
   endfunction

   // Monitor: compares state every cycle and pops the scoreboard on each handshake.
   always @(negedge clk) begin
      int e;
      chk("cmd_ready", 32'(cmd_ready), 32'(m_rdy));
      chk("busy", 32'(busy), 32'(pack4(m_act)));
      chk("ovr", 32'(ovr), 32'(pack4(m_ovr)));
      chk("evt_valid", 32'(evt_valid), 32'(m_off));
      if (m_off) chk("evt_ch_held", 32'(evt_ch), 32'(m_ch));
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL evt_unexpected: got ch %0d expected none at t=%0t", evt_ch, $time);
         end else begin
            e = exp_q.pop_front();
            $display("evt ch=%0d expected=%0d t=%0t", evt_ch, e, $time);
            chk("evt_ch", 32'(evt_ch), 32'(e));
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic cmd(input int ch, input int op, input int per);
      cmd_ch     = 2'(ch);
      cmd_op     = 2'(op);
      cmd_period = 16'(per);
      cmd_valid  = 1'b1;
      $display("cmd ch=%0d op=%0d period=%0d t=%0t", ch, op, per, $time);
      cyc();
      cmd_valid = 1'b0;
   endtask

   initial begin
      bit seen;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_evt_valid", 32'(evt_valid), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_evt_ch", 32'(evt_ch), 32'd0);
      cyc(3);
      rst_n = 1'b1;

      // one-shot ch1 period 3
      cyc(4);
      cmd(1, 1, 3);
      cyc(45);

      // periodic ch0 period 2, then stop
      cmd(0, 2, 2);
      cyc(70);
      cmd(0, 3, 0);
      cyc(40);

      // all channels periodic period 1
      for (int c = 0; c < 4; c++) cmd(c, 2, 1);
      cyc(90);
      for (int c = 0; c < 4; c++) cmd(c, 3, 0);
      cyc(20);

      // overrun on ch2 with consumer stalled, START clears it
      evt_ready = 1'b0;
      cmd(2, 2, 1);
      cyc(40);
      cmd(2, 2, 1);
      evt_ready = 1'b1;
      cyc(30);
      cmd(2, 3, 0);
      cyc(20);

      // START ch3 coinciding with a tick where remain is 1
      cmd(3, 2, 1);
      cyc(12);
      for (int i = 0; i < 2 * TCNT && m_div != TCNT - 1; i++) cyc();
      cmd(3, 2, 4);
      cyc(60);
      cmd(3, 3, 0);
      cyc(20);

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         evt_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) begin
            cmd_ch     = 2'($urandom_range(0, 3));
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_period = 16'($urandom_range(0, 3));
            cmd_valid  = 1'b1;
         end
         cyc();
         cmd_valid = 1'b0;
      end

      // asynchronous reset while an event is being offered
      evt_ready = 1'b0;
      cmd(2, 2, 1);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         if (evt_valid === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL offer_timeout: got evt_valid 0 expected 1 within 40 cycles");
      end
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_evt_valid", 32'(evt_valid), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ovr", 32'(ovr), 32'd0);
      chk("midrst_evt_ch", 32'(evt_ch), 32'd0);
      model_reset();
      cyc(3);
      rst_n = 1'b1;
      evt_ready = 1'b1;
      cmd(1, 1, 2);
      cyc(40);

      // drain
      for (int c = 0; c < 4; c++) cmd(c, 3, 0);
      cyc(30);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the input clock frequency in Hz.
REQ-002 Parameter TICK_FREQ, default 1000, is the base tick frequency in Hz; TICK_CNT = CLK_FREQ/TICK_FREQ clocks per tick.
REQ-003 clk100Mhz  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command strobe, accepted in any cycle with cmd_valid=1 while rst_n=1.
REQ-006 cmd_ready  out  1  constant 1 out of reset (command port never stalls).
REQ-007 cmd_ch  in  2  target channel 0..3.
REQ-008 cmd_op  in  2  operation: 00 NOP, 01 START one-shot, 10 START periodic, 11 STOP.
REQ-009 cmd_period  in  16  period in base ticks, sampled on START only.
REQ-010 busy  out  4  per-channel active flag.
REQ-011 ovr  out  4  per-channel sticky overrun flag.
REQ-012 evt_valid  out  1  expiry event offered.
REQ-013 evt_ch  out  2  channel of offered event, valid while evt_valid=1.
REQ-014 evt_ready  in  1  consumer accepts event when evt_valid&&evt_ready.

Function
REQ-015 Internal free-running divider counts 0..TICK_CNT-1; internal tick pulses for exactly one clock in the cycle the counter equals TICK_CNT-1, then the counter wraps to 0.
REQ-016 Each channel holds active, periodic, period_reg[15:0], remain[15:0], pending, ovr.
REQ-017 START: period_reg=remain=cmd_period (value 0 treated as 1), periodic=cmd_op[1], active=1, ovr cleared; pending unchanged.
REQ-018 STOP: active=0, ovr cleared; pending unchanged (an already-queued event is still delivered).
REQ-019 On internal tick with active=1: remain>1 -> remain-1; remain==1 -> expiry.
REQ-020 Expiry: pending set; periodic -> remain=period_reg, stays active; one-shot -> active=0.
REQ-021 Command to a channel in the same cycle as a tick: command wins, tick ignored for that channel only.
REQ-022 Expiry while pending already set and not cleared that cycle -> ovr set; pending stays 1 (no count of lost events).
REQ-023 Expiry in the same cycle as handshake clear of that channel -> pending remains 1, no overrun.
REQ-024 Event arbiter FSM, two states: IDLE, OFFER.
REQ-025 IDLE: evt_valid=0; if any pending, latch evt_ch = first pending channel searching rr_ptr, rr_ptr+1, ... mod 4; go OFFER.
REQ-026 OFFER: evt_valid=1, evt_ch held stable; on evt_ready clear pending[evt_ch], rr_ptr=evt_ch+1 mod 4, go IDLE.
REQ-027 Latency: tick in cycle T causing expiry -> pending at T+1 -> evt_valid at T+2; one IDLE bubble between consecutive events.
REQ-028 evt_valid never deasserts without handshake; pending/channel state never alter evt_ch while in OFFER.
REQ-029 Multiple channels expiring on the same tick all set pending; delivered in round-robin order.

Reset
REQ-030 rst_n=0 immediately forces: divider=0, all busy/ovr/pending/remain/period_reg=0, rr_ptr=0, FSM IDLE, evt_valid=0, evt_ch=0, cmd_ready=0.
REQ-031 First internal tick occurs TICK_CNT clocks after rst_n release; reset mid-operation discards all pending events.

Verification (CLK_FREQ=100, TICK_FREQ=10, tick every 10 clocks)
REQ-032 START one-shot ch1 period 3, evt_ready=1 -> single event evt_ch=1 two clocks after 3rd tick; busy[1] falls at that tick.
REQ-033 START periodic ch0 period 2, evt_ready=1 -> events every 20 clocks; STOP -> no further events, busy[0]=0.
REQ-034 ch0..ch3 periodic period 1, evt_ready=1, rr_ptr=0 -> evt_ch order 0,1,2,3 repeating; ovr stays 0.
REQ-035 ch2 periodic period 1, evt_ready=0 for 3 ticks -> evt_valid=1, evt_ch=2 held, ovr[2]=1; START ch2 clears ovr[2].
REQ-036 START ch3 issued in tick cycle with remain=1 -> no expiry, remain reloads to cmd_period.
REQ-037 rst_n low during OFFER -> evt_valid=0 same cycle, all outputs per REQ-030.
